apb_completer: RTL and testbench
================================

# apb_completer

APB completer (slave) that terminates transfers issued by the team's APB master agent and backs them with a small word-addressed register bank. It inserts a parameterised number of wait states via `pready`. It is the DUT-side counterpart to the APB VIP's master clocking block and is used both as a bring-up target for the VIP and as the register front end of the ahb2apb bridge's downstream peripherals.

## Interface
- `APB_AW`, 32: address width, bits `[APB_AW-1:0]`.
- `APB_DW`, 32: data width, bits `[APB_DW-1:0]`.
- `NUM_REGS`, 8: number of 32-bit words in the register bank. Must be at least 2 and a power of two.
- `WAIT_STATES`, 0: wait cycles inserted in every access phase. Range 0..15.
- `ID_VALUE`, 32'hA9B0_0001: read-only contents of register 0.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `psel` in 1: select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in APB_AW: byte address. Bits `[1:0]` are ignored.
- `pwdata` in APB_DW: write data.
- `prdata` out APB_DW: read data. It is 0 whenever `pready` is 0 or the transfer is a write.
- `pready` out 1: transfer-complete strobe.

## Operation
- Word index is `idx = paddr[$clog2(NUM_REGS)+1:2]`. An address is in range when `paddr[APB_AW-1:$clog2(NUM_REGS)+2] == 0`.
- Register 0 holds `ID_VALUE` and is read-only. Writes to it are silently dropped.
- Registers 1..NUM_REGS-1 are read/write and reset to 0.
- Out-of-range read returns 0. Out-of-range write is dropped. No error is signalled; the interface has no `pslverr`.
- FSM states:
  - IDLE: `pready`=0. A setup phase (`psel & !penable`) moves to WAIT, or to DONE when `WAIT_STATES`==0. The setup phase also loads `wcnt = WAIT_STATES`.
  - WAIT: `pready`=0. While `psel & penable`, `wcnt` decrements. The FSM moves to DONE when `wcnt` reaches 1. If `psel` drops, it returns to IDLE and no write occurs.
  - DONE: `pready`=1 for exactly one cycle. Next state is always IDLE.
- Write commit happens at the rising edge where `psel & penable & pwrite & pready` are all 1. Address and data are taken from that cycle.
- Read data is registered and loaded on entry to DONE using `paddr` sampled at that edge. `prdata` is valid only while `pready`=1.
- `penable` without a preceding setup phase is ignored. The FSM stays in IDLE and `pready` stays 0.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `pready`=0, `prdata`=0, `wcnt`=0, RW registers=0.
- Setup is cycle T0 and the first access cycle is T1. `pready` is high in cycle T1+`WAIT_STATES` and low in every other cycle.
- A transfer therefore occupies `2+WAIT_STATES` cycles.
- Back-to-back transfers: the cycle after DONE may be the next setup phase. It is accepted with no bubble.
- A write followed immediately by a read of the same index returns the new value.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and `pready` drops asynchronously. No partial write occurs, because a commit requires the completing edge.
- `wcnt` is 4 bits. It never wraps because it loads only at setup and stops at 1.

## Structure
- `apb_pkg` holds:
  - the `apb_state_e` enum (IDLE, WAIT, DONE);
  - the default width localparams;
  - the `ID_VALUE` default constant.
- Sub-module `apb_reg_bank` holds the register array. Its interface is: write enable/index/data, read index, combinational read data, and in-range flag.
- `apb_completer` holds the FSM, the wait counter and the `prdata` register.

## Test plan
- Reset: `reset_n`=0 for 3 cycles, then release. Required: `pready`=0, `prdata`=0, and reading index 1..7 returns 0.
- `WAIT_STATES`=0: write 0xDEADBEEF to 0x04, then read 0x04. Required: `pready` high in T1 of each transfer, and read returns 0xDEADBEEF.
- `WAIT_STATES`=3: read 0x00. Required: `pready` low for 3 access cycles and high in the 4th, with `prdata`=0xA9B00001 in that cycle.
- Write 0x12345678 to 0x00 and 0x55 to 0x40 (out of range), then read both. Required: 0x00 returns 0xA9B00001 and 0x40 returns 0.
- Back-to-back: write 0x1 to 0x08 with the read of 0x08 starting the next cycle. Required: read returns 0x1 with no idle cycle between transfers.
- With `WAIT_STATES`=3, assert `reset_n`=0 during the 2nd wait cycle of a write of 0xFF to 0x0C. Required: `pready` never rises, and reading 0x0C afterwards returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB completer and its register bank.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

  localparam int APB_AW_DEF      = 32;
  localparam int APB_DW_DEF      = 32;
  localparam int NUM_REGS_DEF    = 8;
  localparam int WAIT_STATES_DEF = 0;

  localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;

endpackage

// File: rtl/apb_reg_bank.sv
// Word-addressed register bank: word 0 is a read-only ID, the rest are RW and reset to 0.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                APB_AW   = APB_AW_DEF,
  parameter int                APB_DW   = APB_DW_DEF,
  parameter int                NUM_REGS = NUM_REGS_DEF,
  parameter logic [APB_DW-1:0] ID_VALUE = APB_ID_VALUE
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [APB_DW-1:0]           wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [APB_DW-1:0]           rd_data,
  input  logic [APB_AW-1:0]           addr,
  output logic                        in_range
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [APB_DW-1:0] regs_r [NUM_REGS];
  logic              unused_addr_bits;

  // Index and byte-lane bits are decoded by the caller; only the upper bits matter here.
  assign unused_addr_bits = ^addr[IDX_W+1:0];

  // Address is in range when every bit above the word index is zero.
  always_comb begin
    in_range = 1'b0;
    if (addr[APB_AW-1:IDX_W+2] == {(APB_AW-IDX_W-2){1'b0}}) begin
      in_range = 1'b1;
    end else begin
      in_range = 1'b0;
    end
  end

  // Register storage; slot 0 is never written so the ID word stays constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {APB_DW{1'b0}};
      end
    end else if (wr_en && (wr_idx != {IDX_W{1'b0}})) begin
      regs_r[wr_idx] <= wr_data;
    end
  end

  // Combinational read port with the ID word substituted at index 0.
  always_comb begin
    rd_data = {APB_DW{1'b0}};
    if (rd_idx == {IDX_W{1'b0}}) begin
      rd_data = ID_VALUE;
    end else begin
      rd_data = regs_r[rd_idx];
    end
  end

endmodule

// File: rtl/apb_completer.sv
// APB completer: wait-state FSM, registered pready/prdata, backed by apb_reg_bank.
module apb_completer
  import apb_pkg::*;
#(
  parameter int                APB_AW      = APB_AW_DEF,
  parameter int                APB_DW      = APB_DW_DEF,
  parameter int                NUM_REGS    = NUM_REGS_DEF,
  parameter int                WAIT_STATES = WAIT_STATES_DEF,
  parameter logic [APB_DW-1:0] ID_VALUE    = APB_ID_VALUE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready
);

  localparam int         IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  apb_state_e        state_r, state_s;
  logic [3:0]        wcnt_r, wcnt_s;
  logic              pready_r;
  logic [APB_DW-1:0] prdata_r, prdata_s;
  logic [IDX_W-1:0]  idx_s;
  logic [APB_DW-1:0] bank_rdata_s;
  logic              in_range_s;
  logic              wr_en_s;

  assign idx_s = paddr[IDX_W+1:2];

  apb_reg_bank #(
    .APB_AW   (APB_AW),
    .APB_DW   (APB_DW),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en_s),
    .wr_idx   (idx_s),
    .wr_data  (pwdata),
    .rd_idx   (idx_s),
    .rd_data  (bank_rdata_s),
    .addr     (paddr),
    .in_range (in_range_s)
  );

  // Commit only on the completing edge, so an aborted transfer never writes.
  always_comb begin
    wr_en_s = 1'b0;
    if (psel && penable && pwrite && pready_r && in_range_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Next-state and wait-counter logic; the counter loads at setup and stops at 1.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          wcnt_s = WS;
          if (WS == 4'd0) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_s = IDLE;
        end else if (penable) begin
          if (wcnt_r <= 4'd1) begin
            state_s = DONE;
          end else begin
            wcnt_s = wcnt_r - 4'd1;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read data is captured on entry to DONE and is zero in every other cycle.
  always_comb begin
    prdata_s = {APB_DW{1'b0}};
    if ((state_s == DONE) && (state_r != DONE) && !pwrite && in_range_s) begin
      prdata_s = bank_rdata_s;
    end else begin
      prdata_s = {APB_DW{1'b0}};
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      wcnt_r   <= 4'd0;
      pready_r <= 1'b0;
      prdata_r <= {APB_DW{1'b0}};
    end else begin
      state_r  <= state_s;
      wcnt_r   <= wcnt_s;
      pready_r <= (state_s == DONE);
      prdata_r <= prdata_s;
    end
  end

  assign pready = pready_r;
  assign prdata = prdata_r;

endmodule

// File: tb/tb_apb_completer.sv
// Randomized self-checking bench: two completers (0 and 3 wait states) against a register-array model.
module tb_apb_completer;

  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model [2][NR];

  always #5 clk = ~clk;

  apb_completer #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata0), .pready(pready0)
  );

  apb_completer #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata3), .pready(pready3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? pready0 : pready3;
  endfunction

  function automatic logic [31:0] prd(input int u);
    return (u == 0) ? prdata0 : prdata3;
  endfunction

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] ref_read(input int u, input logic [31:0] a);
    if (a[31:5] != 27'd0) return 32'd0;
    if (a[4:2] == 3'd0) return ID;
    return model[u][a[4:2]];
  endfunction

  function automatic void ref_write(input int u, input logic [31:0] a, input logic [31:0] d);
    if (a[31:5] == 27'd0 && a[4:2] != 3'd0) model[u][a[4:2]] = d;
  endfunction

  function automatic void ref_reset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < NR; i++) model[u][i] = 32'd0;
  endfunction

  // One complete transfer starting at posedge+1; leaves the bus deselected at posedge+1.
  task automatic xfer(input int u, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    int ws;
    ws  = ws_of(u);
    exp = wr ? 32'd0 : ref_read(u, a);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
    @(negedge clk);
    check_eq("setup_pready", {31'd0, rdy(u)}, 32'd0);
    @(posedge clk); #1;
    penable[u] = 1'b1;
    for (int k = 0; k <= ws; k++) begin
      @(negedge clk);
      if (k == ws) begin
        check_eq("done_pready", {31'd0, rdy(u)}, 32'd1);
        if (wr) check_eq("wr_prdata", prd(u), exp);
        else    check_eq("rd_prdata", prd(u), exp);
      end else begin
        check_eq("wait_pready", {31'd0, rdy(u)}, 32'd0);
        check_eq("wait_prdata", prd(u), 32'd0);
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    psel[u] = 1'b0; penable[u] = 1'b0;
    if (wr) ref_write(u, a, d);
  endtask

  task automatic idle(input int u, input int n);
    psel[u] = 1'b0; penable[u] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_pready", {31'd0, rdy(u)}, 32'd0);
      check_eq("idle_prdata", prd(u), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // penable with no setup phase must be ignored and must not write.
  task automatic stray(input int u);
    psel[u] = 1'b1; penable[u] = 1'b1; pwrite[u] = 1'b1;
    paddr[u] = 32'h8; pwdata[u] = $urandom;
    repeat (2) begin
      @(negedge clk);
      check_eq("stray_pready", {31'd0, rdy(u)}, 32'd0);
      @(posedge clk); #1;
    end
    psel[u] = 1'b0; penable[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int u;
    ref_reset();
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 32'd0; pwdata[i] = 32'd0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pready0", {31'd0, pready0}, 32'd0);
    check_eq("rst_prdata0", prdata0, 32'd0);
    check_eq("rst_pready3", {31'd0, pready3}, 32'd0);
    check_eq("rst_prdata3", prdata3, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(0, 1);

    for (int v = 0; v < 2; v++)
      for (int i = 1; i < NR; i++) xfer(v, 1'b0, 32'(i * 4), 32'd0);

    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h04, 32'd0);
    xfer(1, 1'b0, 32'h00, 32'd0);
    xfer(0, 1'b1, 32'h00, 32'h12345678);
    xfer(0, 1'b1, 32'h40, 32'h55);
    xfer(0, 1'b0, 32'h00, 32'd0);
    xfer(0, 1'b0, 32'h40, 32'd0);
    xfer(0, 1'b1, 32'h08, 32'h1);
    xfer(0, 1'b0, 32'h08, 32'd0);
    xfer(1, 1'b1, 32'h10, 32'hCAFE0001);
    xfer(1, 1'b0, 32'h10, 32'd0);
    stray(0);
    xfer(0, 1'b0, 32'h08, 32'd0);

    for (int n = 0; n < 80; n++) begin
      u = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000;
      case ($urandom_range(0, 5))
        0:       idle(u, int'($urandom_range(1, 2)));
        1:       stray(u);
        default: ;
      endcase
      xfer(u, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Abort a write to 0x0C on the 3-wait-state completer during its 2nd wait cycle.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'hFF;
    @(negedge clk);
    check_eq("abort_setup_pready", {31'd0, pready3}, 32'd0);
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    check_eq("abort_w1_pready", {31'd0, pready3}, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    ref_reset();
    @(negedge clk);
    check_eq("abort_rst_pready", {31'd0, pready3}, 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_hold_pready", {31'd0, pready3}, 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1, 2);
    xfer(1, 1'b0, 32'h0C, 32'd0);
    xfer(1, 1'b0, 32'h10, 32'd0);
    xfer(0, 1'b0, 32'h04, 32'd0);
    xfer(1, 1'b0, 32'h00, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
